// File: rtl/brpred_pkg.sv
// Shared definitions for the gshare branch predictor: counter encodings,
// the reset-value default and the saturating counter step.
package brpred_pkg;

    localparam int unsigned CNT_W_MAX        = 4;
    localparam int unsigned CNT_BITS_DEFAULT = 2;
    localparam int unsigned STAT_W           = 16;

    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'd0,
        CNT_WEAK_NT   = 2'd1,
        CNT_WEAK_T    = 2'd2,
        CNT_STRONG_T  = 2'd3
    } cnt2_e;

    // Weakly-taken midpoint for a counter of the given width.
    function automatic int unsigned cnt_init_default(input int unsigned cnt_bits);
        return 32'd1 << (cnt_bits - 1);
    endfunction

    function automatic logic [CNT_W_MAX-1:0] cnt_sat_step(
        input logic [CNT_W_MAX-1:0] cnt,
        input logic                 up,
        input int unsigned          cnt_bits
    );
        logic [CNT_W_MAX-1:0] cnt_max;
        cnt_max = CNT_W_MAX'((32'd1 << cnt_bits) - 32'd1);
        if (up) begin
            return (cnt == cnt_max) ? cnt : cnt + 1'b1;
        end
        return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/brpred_ghr.sv
// Speculative and architectural global history registers with mispredict
// recovery; drives the speculative history zero-extended to the index width.
module brpred_ghr
    import brpred_pkg::*;
#(
    parameter int unsigned HIST_LEN = 3,
    parameter int unsigned IDX_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid_i,
    input  logic             pred_taken_i,
    input  logic             upd_valid_i,
    input  logic             upd_taken_i,
    input  logic             upd_mispred_i,
    output logic [IDX_W-1:0] hist_o
);

    generate
        if (HIST_LEN > 0) begin : g_hist
            logic [HIST_LEN-1:0] spec_q;
            logic [HIST_LEN-1:0] arch_q;
            logic [HIST_LEN-1:0] spec_next;
            logic [HIST_LEN-1:0] arch_next;
            logic [HIST_LEN:0]   arch_shift;
            logic [HIST_LEN:0]   spec_shift;

            always_comb begin
                arch_shift = {arch_q, upd_taken_i};
                spec_shift = {spec_q, pred_taken_i};
                arch_next  = arch_shift[HIST_LEN-1:0];
                // NOTE: every always_comb output gets a default first so no path infers a latch.
                spec_next  = spec_q;
                // A resolved mispredict rewinds speculation to the true history.
                if (upd_valid_i && upd_mispred_i) begin
                    spec_next = arch_next;
                end else if (pred_valid_i) begin
                    spec_next = spec_shift[HIST_LEN-1:0];
                end
            end

            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    spec_q <= '0;
                    arch_q <= '0;
                end else begin
                    spec_q <= spec_next;
                    if (upd_valid_i) begin
                        arch_q <= arch_next;
                    end
                end
            end

            assign hist_o = IDX_W'(spec_q);
        end else begin : g_no_hist
            logic unused_hist_inputs;
            assign unused_hist_inputs = ^{clk, rst_n, pred_valid_i, pred_taken_i,
                                          upd_valid_i, upd_taken_i, upd_mispred_i};
            assign hist_o = '0;
        end
    endgenerate

endmodule

// File: rtl/brpred_gshare.sv
// Gshare branch predictor: PC-xor-history indexed table of saturating
// counters, combinational prediction, resolved-branch training and stats.
module brpred_gshare
    import brpred_pkg::*;
#(
    parameter int unsigned NUM_INDEX_BIT = 3,
    parameter int unsigned HIST_LEN      = 3,
    parameter int unsigned CNT_BITS      = CNT_BITS_DEFAULT,
    parameter int unsigned CNT_INIT      = cnt_init_default(CNT_BITS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pred_valid_i,
    input  logic [31:0]              pred_pc_i,
    output logic                     pred_taken_o,
    output logic [NUM_INDEX_BIT-1:0] pred_idx_o,
    input  logic                     upd_valid_i,
    input  logic [NUM_INDEX_BIT-1:0] upd_idx_i,
    input  logic                     upd_taken_i,
    input  logic                     upd_mispred_i,
    output logic [STAT_W-1:0]        stat_pred_o,
    output logic [STAT_W-1:0]        stat_miss_o
);

    localparam int unsigned NUM_ENTRIES = 1 << NUM_INDEX_BIT;

    logic [CNT_BITS-1:0]      pht_q [NUM_ENTRIES];
    logic [CNT_BITS-1:0]      upd_cnt_next;
    logic [NUM_INDEX_BIT-1:0] hist;
    logic [STAT_W-1:0]        stat_pred_q;
    logic [STAT_W-1:0]        stat_miss_q;
    logic                     unused_pc_bits;

    brpred_ghr #(
        .HIST_LEN (HIST_LEN),
        .IDX_W    (NUM_INDEX_BIT)
    ) u_ghr (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_valid_i  (pred_valid_i),
        .pred_taken_i  (pred_taken_o),
        .upd_valid_i   (upd_valid_i),
        .upd_taken_i   (upd_taken_i),
        .upd_mispred_i (upd_mispred_i),
        .hist_o        (hist)
    );

    assign pred_idx_o     = pred_pc_i[NUM_INDEX_BIT+1:2] ^ hist;
    assign pred_taken_o   = pred_valid_i & pht_q[pred_idx_o][CNT_BITS-1];
    assign unused_pc_bits = ^{pred_pc_i[31:NUM_INDEX_BIT+2], pred_pc_i[1:0]};
    assign upd_cnt_next   = CNT_BITS'(cnt_sat_step(CNT_W_MAX'(pht_q[upd_idx_i]),
                                                   upd_taken_i, CNT_BITS));

    // NOTE: the table is flops rather than RAM, so it can be reset and read asynchronously;
    // the read above therefore sees the pre-update counter on a same-index write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                pht_q[i] <= CNT_BITS'(CNT_INIT);
            end
        end else if (upd_valid_i) begin
            pht_q[upd_idx_i] <= upd_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pred_q <= '0;
            stat_miss_q <= '0;
        end else if (upd_valid_i) begin
            if (stat_pred_q != '1) begin
                stat_pred_q <= stat_pred_q + 1'b1;
            end
            if (upd_mispred_i && stat_miss_q != '1) begin
                stat_miss_q <= stat_miss_q + 1'b1;
            end
        end
    end

    assign stat_pred_o = stat_pred_q;
    assign stat_miss_o = stat_miss_q;

endmodule

// File: doc/brpred_gshare.md
BRPRED_GSHARE -- requirements
Module: brpred_gshare

Interface
REQ-001 SHALL have parameter NUM_INDEX_BIT, default 3, meaning log2 of pattern-table entries.
REQ-002 SHALL have parameter HIST_LEN, default 3, meaning global-history length; legal 0..NUM_INDEX_BIT.
REQ-003 SHALL have parameter CNT_BITS, default 2, meaning saturating-counter width; legal 2..4.
REQ-004 SHALL have parameter CNT_INIT, default 2**(CNT_BITS-1), meaning counter value after reset (weakly taken).
REQ-005 SHALL have ports: clk  in  1  clock, all state on rising edge; rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports: pred_valid_i  in  1  a branch is being fetched this cycle; pred_pc_i  in  32  fetch PC.
REQ-007 SHALL have ports: pred_taken_o  out  1  predicted taken; pred_idx_o  out  NUM_INDEX_BIT  table index used, carried down the pipe.
REQ-008 SHALL have ports: upd_valid_i  in  1  branch resolved; upd_idx_i  in  NUM_INDEX_BIT  index from pred_idx_o; upd_taken_i  in  1  actual outcome; upd_mispred_i  in  1  prediction was wrong.
REQ-009 SHALL have ports: stat_pred_o  out  16  resolved-branch count; stat_miss_o  out  16  mispredict count.

Function
REQ-010 SHALL compute pred_idx_o = pred_pc_i[NUM_INDEX_BIT+1:2] XOR zero-extended speculative GHR, combinationally.
REQ-011 SHALL drive pred_taken_o = pred_valid_i AND counter[pred_idx_o] MSB, combinationally (zero-cycle latency).
REQ-012 SHALL shift pred_taken_o into the LSB of the speculative GHR on each clock with pred_valid_i=1, discarding the MSB.
REQ-013 SHALL shift upd_taken_i into the architectural GHR on each clock with upd_valid_i=1.
REQ-014 SHALL, on upd_valid_i=1, increment counter[upd_idx_i] if upd_taken_i=1 else decrement, saturating at 2**CNT_BITS-1 and 0.
REQ-015 SHALL update counters on every resolved branch, not only on mispredicts.
REQ-016 SHALL, on upd_valid_i=1 and upd_mispred_i=1, load the speculative GHR with the architectural GHR's next value (including upd_taken_i), overriding REQ-012 that cycle.
REQ-017 SHALL ignore upd_mispred_i when upd_valid_i=0.
REQ-018 SHALL, when prediction and update address the same index in one cycle, predict from the pre-update counter (read-before-write).
REQ-019 SHALL, with HIST_LEN=0, degenerate to a PC-indexed table with both GHRs absent.
REQ-020 SHALL increment stat_pred_o per upd_valid_i and stat_miss_o per upd_valid_i AND upd_mispred_i, each saturating at 16'hFFFF.

Reset
REQ-021 SHALL, with rst_n=0 at a clock edge, set every counter to CNT_INIT, both GHRs to 0 and both stat outputs to 0, overriding any same-cycle update.
REQ-022 SHALL keep pred_taken_o purely combinational, so it equals pred_valid_i AND CNT_INIT MSB while reset state holds.
REQ-023 SHALL accept rst_n assertion mid-operation, dropping all in-flight history without further effect.

Structure
REQ-024 SHALL place counter-state constants, CNT_INIT default and the saturating inc/dec function in shared package brpred_pkg.
REQ-025 SHALL implement both history registers plus the recovery mux in one sub-module brpred_ghr (parameter HIST_LEN).
REQ-026 SHALL hold the pattern table in flops, not inferred RAM, to support read-before-write with asynchronous read.

Verification
REQ-027 SHALL check that after reset, pred_valid_i=1 with any PC gives pred_taken_o=1 and both stats read 0.
REQ-028 SHALL check that 3 consecutive updates idx=5 taken=0 drive counter 2->1->0->0, after which a prediction at idx 5 gives 0.
REQ-029 SHALL check that 3 predictions of taken give spec GHR=3'b111, and that PC 0x10 then gives pred_idx_o=3'b100^3'b111=3'b011.
REQ-030 SHALL check that with arch GHR=3'b010, upd_valid_i=1, upd_mispred_i=1, upd_taken_i=1 and simultaneous pred_valid_i, next spec GHR=3'b101.
REQ-031 SHALL check that a same-cycle predict and update at idx 2, counter=1, update taken, gives pred_taken_o=0 that cycle and 1 the next.
REQ-032 SHALL check that 65536 mispredicted updates leave stat_miss_o=16'hFFFF, and that rst_n=0 on the same cycle as an update gives all-reset state.
